// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Brief   : Shared MD op encodings, controller state encoding, default latencies
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } mdOp_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mduState_e;

  localparam int c_MULT_LAT_DEF = 5;
  localparam int c_DIV_LAT_DEF  = 10;
  localparam int c_CNT_W_DEF    = 4;

  // True for the ops that occupy the multi-cycle window.
  function automatic logic isMdArith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_calc.sv
// ============================================================================
// Module  : mdu_calc
// Brief   : Combinational MULT/MULTU/DIV/DIVU datapath on latched operands
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic [31:0] resHi,
  output logic [31:0] resLo,
  output logic        div0
);

  logic [63:0] w_prodS;
  logic [63:0] w_prodU;
  logic        w_signedDiv;
  logic [31:0] w_magA;
  logic [31:0] w_magB;
  logic [31:0] w_divisor;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_prodS = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
  assign w_prodU = {32'd0, opA} * {32'd0, opB};

  // Signed division runs on magnitudes, so INT_MIN / -1 wraps instead of overflowing.
  assign w_signedDiv = (op == MD_DIV);
  assign w_magA      = (w_signedDiv && opA[31]) ? (32'd0 - opA) : opA;
  assign w_magB      = (w_signedDiv && opB[31]) ? (32'd0 - opB) : opB;
  assign w_divisor   = (opB == 32'd0) ? 32'd1 : w_magB;
  assign w_quot      = w_magA / w_divisor;
  assign w_rem       = w_magA % w_divisor;

  always_comb begin
    resHi = 32'd0;
    resLo = 32'd0;
    div0  = 1'b0;
    case (mdOp_e'(op))
      MD_MULT:  {resHi, resLo} = w_prodS;
      MD_MULTU: {resHi, resLo} = w_prodU;
      MD_DIV: begin
        resLo = (opA[31] ^ opB[31]) ? (32'd0 - w_quot) : w_quot;
        resHi = opA[31] ? (32'd0 - w_rem) : w_rem;
        div0  = (opB == 32'd0);
      end
      MD_DIVU: begin
        resLo = w_quot;
        resHi = w_rem;
        div0  = (opB == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module  : mdu_ctrl
// Brief   : MD unit sequencer: busy window, operand latches, HI/LO registers
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = c_MULT_LAT_DEF,
  parameter int DIV_LAT  = c_DIV_LAT_DEF,
  parameter int CNT_W    = c_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  mduState_e        r_state;
  mduState_e        w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             r_busy;
  logic             w_nextBusy;
  logic [2:0]       r_op;
  logic [31:0]      r_opA;
  logic [31:0]      r_opB;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      w_nextHi;
  logic [31:0]      w_nextLo;
  logic             w_latch;
  logic [31:0]      w_resHi;
  logic [31:0]      w_resLo;
  logic             w_div0;

  mdu_calc u_calc (
    .op    (r_op),
    .opA   (r_opA),
    .opB   (r_opB),
    .resHi (w_resHi),
    .resLo (w_resLo),
    .div0  (w_div0)
  );

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextBusy  = r_busy;
    w_nextHi    = r_hi;
    w_nextLo    = r_lo;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (mdOp_e'(op))
            MD_MULT, MD_MULTU: begin
              w_latch     = 1'b1;
              w_nextCnt   = c_MULT_CNT;
              w_nextBusy  = 1'b1;
              w_nextState = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              w_latch     = 1'b1;
              w_nextCnt   = c_DIV_CNT;
              w_nextBusy  = 1'b1;
              w_nextState = ST_RUN;
            end
            MD_MTHI: w_nextHi = a;
            MD_MTLO: w_nextLo = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // A start here breaks the hazard contract and is deliberately ignored.
        w_nextCnt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_nextState = ST_IDLE;
          w_nextBusy  = 1'b0;
          w_nextCnt   = '0;
          if (!w_div0) begin
            w_nextHi = w_resHi;
            w_nextLo = w_resLo;
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_op    <= MD_NOP;
      r_opA   <= 32'd0;
      r_opB   <= 32'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_busy  <= w_nextBusy;
      r_hi    <= w_nextHi;
      r_lo    <= w_nextLo;
      if (w_latch) begin
        r_op  <= op;
        r_opA <= a;
        r_opB <= b;
      end
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire
